instr_loader: RTL and testbench

Byte-stream program loader: the writer side of the instruction memory. It consumes bytes from the serial receive path, frames them as a program image, and writes them sequentially into the writable instruction memory. It verifies a checksum and holds the CPU in reset while loading. It sits between the UART receiver and the instruction memory write port, alongside the CPU reset logic.

---
 rtl/instr_loader_pkg.sv | 26 ++
 rtl/instr_loader_timeout.sv | 36 +++
 rtl/instr_loader.sv | 168 ++++++++++++++++
 tb/tb_instr_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the byte-stream program loader: FSM state encoding,
// default frame start marker and the remaining-count width (LEN=0 means 256).
package instr_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LEN  = 2'd1,
      ST_DATA = 2'd2,
      ST_SUM  = 2'd3
   } ld_state_t;

   localparam logic [7:0] START_BYTE_DEF = 8'hA5;
   localparam int         COUNT_W        = 9;

   // Map the LEN byte to a remaining-byte count; 0 encodes a full 256-byte image.
   function automatic logic [COUNT_W-1:0] len_to_count(input logic [7:0] len);
      logic [COUNT_W-1:0] cnt;
      if (len == 8'd0) begin
         cnt = 9'h100;
      end else begin
         cnt = {1'b0, len};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/instr_loader_timeout.sv
// loader_timeout: parameterised inter-byte watchdog. Counts while enabled,
// restarts on clear, and pulses expire in the cycle the count sits at
// TIMEOUT_CYCLES-1 (a clear in that same cycle suppresses the pulse).
module loader_timeout #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int            CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_r;
   logic          hit_s;

   assign hit_s  = enable && !clear && (count_r == LAST);
   assign expire = hit_s;

   // Cycle counter: restart on clear or after firing, otherwise advance while enabled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_r <= '0;
      end else if (clear || hit_s) begin
         count_r <= '0;
      end else if (enable) begin
         count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: frames START/LEN/data/SUM byte streams from the UART into
// sequential instruction-memory writes, checks the modulo-256 sum, and keeps
// the CPU held in reset until an image has loaded cleanly.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter logic [7:0] START_BYTE     = START_BYTE_DEF,
   parameter int         TIMEOUT_CYCLES = 1000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       cpu_hold,
   output logic       load_done,
   output logic       load_err
);

   ld_state_t          state_r,     next_state_s;
   logic [7:0]         ptr_r,       ptr_s;
   logic [COUNT_W-1:0] cnt_r,       cnt_s;
   logic [7:0]         acc_r,       acc_s;
   logic               mem_we_r,    mem_we_s;
   logic [7:0]         mem_addr_r,  mem_addr_s;
   logic [7:0]         mem_wdata_r, mem_wdata_s;
   logic               cpu_hold_r,  cpu_hold_s;
   logic               load_done_r, load_done_s;
   logic               load_err_r,  load_err_s;

   logic               to_clear_s;
   logic               to_enable_s;
   logic               to_expire_s;

   // The watchdog restarts on every byte and is held clear while idle.
   assign to_clear_s  = rx_valid || (state_r == ST_IDLE);
   assign to_enable_s = (state_r != ST_IDLE);

   loader_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clock  (clock),
      .reset  (reset),
      .clear  (to_clear_s),
      .enable (to_enable_s),
      .expire (to_expire_s)
   );

   // State register and all registered outputs; async reset returns to IDLE at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         ptr_r       <= 8'd0;
         cnt_r       <= '0;
         acc_r       <= 8'd0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= 8'd0;
         mem_wdata_r <= 8'd0;
         cpu_hold_r  <= 1'b0;
         load_done_r <= 1'b0;
         load_err_r  <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         ptr_r       <= ptr_s;
         cnt_r       <= cnt_s;
         acc_r       <= acc_s;
         mem_we_r    <= mem_we_s;
         mem_addr_r  <= mem_addr_s;
         mem_wdata_r <= mem_wdata_s;
         cpu_hold_r  <= cpu_hold_s;
         load_done_r <= load_done_s;
         load_err_r  <= load_err_s;
      end
   end

   // Next-state and next-output logic; a received byte takes priority over a timeout.
   always_comb begin
      next_state_s = state_r;
      ptr_s        = ptr_r;
      cnt_s        = cnt_r;
      acc_s        = acc_r;
      mem_we_s     = 1'b0;
      mem_addr_s   = mem_addr_r;
      mem_wdata_s  = mem_wdata_r;
      cpu_hold_s   = cpu_hold_r;
      load_done_s  = load_done_r;
      load_err_s   = load_err_r;

      case (state_r)
         ST_IDLE: begin
            if (rx_valid && (rx_data == START_BYTE)) begin
               next_state_s = ST_LEN;
               cpu_hold_s   = 1'b1;
               load_done_s  = 1'b0;
               load_err_s   = 1'b0;
               ptr_s        = 8'd0;
               acc_s        = 8'd0;
            end else begin
               next_state_s = ST_IDLE;
            end
         end

         ST_LEN: begin
            if (rx_valid) begin
               cnt_s        = len_to_count(rx_data);
               next_state_s = ST_DATA;
            end else if (to_expire_s) begin
               next_state_s = ST_IDLE;
               load_err_s   = 1'b1;
            end else begin
               next_state_s = ST_LEN;
            end
         end

         ST_DATA: begin
            if (rx_valid) begin
               mem_we_s    = 1'b1;
               mem_addr_s  = ptr_r;
               mem_wdata_s = rx_data;
               acc_s       = acc_r + rx_data;
               ptr_s       = ptr_r + 8'd1;
               cnt_s       = cnt_r - 9'd1;
               if (cnt_r == 9'd1) begin
                  next_state_s = ST_SUM;
               end else begin
                  next_state_s = ST_DATA;
               end
            end else if (to_expire_s) begin
               next_state_s = ST_IDLE;
               load_err_s   = 1'b1;
            end else begin
               next_state_s = ST_DATA;
            end
         end

         ST_SUM: begin
            if (rx_valid) begin
               next_state_s = ST_IDLE;
               if (rx_data == acc_r) begin
                  load_done_s = 1'b1;
                  cpu_hold_s  = 1'b0;
               end else begin
                  load_err_s  = 1'b1;
               end
            end else if (to_expire_s) begin
               next_state_s = ST_IDLE;
               load_err_s   = 1'b1;
            end else begin
               next_state_s = ST_SUM;
            end
         end

         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign cpu_hold  = cpu_hold_r;
   assign load_done = load_done_r;
   assign load_err  = load_err_r;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: good/bad checksum frames, a 256-byte
// back-to-back image, inter-byte timeout, idle noise and mid-frame reset.
module tb_instr_loader;
   import instr_loader_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_hold;
   logic       load_done;
   logic       load_err;

   instr_loader #(
      .START_BYTE     (8'hA5),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .load_err  (load_err)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Memory image and write statistics observed on the write port.
   logic [7:0] mem [256];
   int         wr_total    = 0;
   int         cyc         = 0;
   int         last_wr_cyc = -10;
   int         streak      = 0;
   logic [7:0] last_wr_addr = 8'd0;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (!reset && mem_we) begin
         mem[mem_addr] <= mem_wdata;
         wr_total      <= wr_total + 1;
         streak        <= (last_wr_cyc == cyc - 1) ? streak + 1 : 1;
         last_wr_cyc   <= cyc;
         last_wr_addr  <= mem_addr;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One strobe, then rx_valid low; returns just after the following falling edge.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clock);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clock);
      rx_valid = 1'b0;
      #1;
   endtask

   // n strobes on consecutive cycles carrying 0,1,2,...; rx_valid left high.
   task automatic send_ramp(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         rx_data  = 8'(i);
         rx_valid = 1'b1;
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_we"},    32'(mem_we),    32'd0);
      check({tag, "_addr"},  32'(mem_addr),  32'd0);
      check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
      check({tag, "_hold"},  32'(cpu_hold),  32'd0);
      check({tag, "_done"},  32'(load_done), 32'd0);
      check({tag, "_err"},   32'(load_err),  32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int bad;

      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'd0;
      #12;
      check_outputs_zero("reset");
      @(negedge clock);
      reset = 1'b0;

      // Good three-byte frame, sum C0+D7+03 = 0x19A -> 9A.
      base = wr_total;
      send_byte(8'hA5);
      check("t1_hold_start", 32'(cpu_hold), 32'd1);
      send_byte(8'h03);
      send_byte(8'hC0);
      check("t1_we_lat",    32'(mem_we),    32'd1);
      check("t1_addr0",     32'(mem_addr),  32'd0);
      check("t1_wdata0",    32'(mem_wdata), 32'hC0);
      @(posedge clock);
      #1;
      check("t1_we_drop",   32'(mem_we),    32'd0);
      send_byte(8'hD7);
      check("t1_addr1",     32'(mem_addr),  32'd1);
      check("t1_wdata1",    32'(mem_wdata), 32'hD7);
      send_byte(8'h03);
      send_byte(8'h9A);
      check("t1_done",      32'(load_done), 32'd1);
      check("t1_hold",      32'(cpu_hold),  32'd0);
      check("t1_err",       32'(load_err),  32'd0);
      check("t1_writes",    32'(wr_total - base), 32'd3);
      check("t1_mem0",      32'(mem[0]), 32'hC0);
      check("t1_mem1",      32'(mem[1]), 32'hD7);
      check("t1_mem2",      32'(mem[2]), 32'h03);

      // Same frame with a wrong sum.
      base = wr_total;
      send_byte(8'hA5);
      check("t2_done_clr",  32'(load_done), 32'd0);
      send_byte(8'h03);
      send_byte(8'hC0);
      send_byte(8'hD7);
      send_byte(8'h03);
      send_byte(8'h9B);
      check("t2_err",       32'(load_err),  32'd1);
      check("t2_hold",      32'(cpu_hold),  32'd1);
      check("t2_done",      32'(load_done), 32'd0);
      check("t2_writes",    32'(wr_total - base), 32'd3);

      // LEN=0: 256 back-to-back bytes of value i, sum 0x7F80 -> 80.
      base = wr_total;
      send_byte(8'hA5);
      send_byte(8'h00);
      send_ramp(256);
      send_byte(8'h80);
      check("t3_writes",    32'(wr_total - base), 32'd256);
      check("t3_streak",    32'(streak), 32'd256);
      check("t3_last_addr", 32'(last_wr_addr), 32'hFF);
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         if (mem[i] !== 8'(i)) bad++;
      end
      check("t3_mem",       32'(bad), 32'd0);
      check("t3_done",      32'(load_done), 32'd1);
      check("t3_hold",      32'(cpu_hold),  32'd0);
      check("t3_ptr_wrap",  32'(dut.ptr_r), 32'd0);

      // Timeout: LEN=2, one data byte, then silence.
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'hC0);
      repeat (8) @(negedge clock);
      #1;
      check("t4_err_early", 32'(load_err), 32'd0);
      check("t4_in_data",   32'(dut.state_r), 32'(ST_DATA));
      repeat (12) @(negedge clock);
      #1;
      check("t4_err",       32'(load_err),  32'd1);
      check("t4_hold",      32'(cpu_hold),  32'd1);
      check("t4_idle",      32'(dut.state_r), 32'(ST_IDLE));
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h5A);
      send_byte(8'h5A);
      check("t4_rec_done",  32'(load_done), 32'd1);
      check("t4_rec_hold",  32'(cpu_hold),  32'd0);
      check("t4_rec_mem",   32'(mem[0]), 32'h5A);

      // Noise bytes while idle change nothing.
      base = wr_total;
      send_byte(8'h11);
      send_byte(8'h22);
      check("t5_writes",    32'(wr_total - base), 32'd0);
      check("t5_done",      32'(load_done), 32'd1);
      check("t5_err",       32'(load_err),  32'd0);
      check("t5_hold",      32'(cpu_hold),  32'd0);

      // Reset mid-DATA, observed before the next rising edge.
      send_byte(8'hA5);
      send_byte(8'h04);
      send_byte(8'h01);
      send_byte(8'h02);
      check("t6_we_pre",    32'(mem_we), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      check_outputs_zero("t6_async");
      check("t6_idle",      32'(dut.state_r), 32'(ST_IDLE));
      @(negedge clock);
      reset = 1'b0;
      base = wr_total;
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h55);
      send_byte(8'h66);
      send_byte(8'hBB);
      check("t6_writes",    32'(wr_total - base), 32'd2);
      check("t6_mem0",      32'(mem[0]), 32'h55);
      check("t6_mem1",      32'(mem[1]), 32'h66);
      check("t6_done",      32'(load_done), 32'd1);
      check("t6_hold",      32'(cpu_hold),  32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
